mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Initiator-side memory controller for the multicycle MIPS datapath.
- Accepts load/store requests (byte, half, word) over a valid/ready handshake and drives the word-addressed memory system: ROM below RAM_BASE, RAM at and above it.
- Aligns addresses, performs read-modify-write for sub-word stores, and extracts and extends sub-word load data.
- Returns exactly one response pulse per accepted request.

Parameters:
- DATA_WIDTH, 32, data and address width.
- RAM_BASE, 32'h1000_0000, first writable address; writes below it are errors.
- READ_LAT, 1, cycles from address presentation until mem_rdata_i is valid; must be at least 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  controller can accept a request.
- req_we_i  input  1  1 = store, 0 = load.
- req_size_i  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_sign_i  input  1  sign-extend sub-word loads.
- req_addr_i  input  DATA_WIDTH  byte address.
- req_wdata_i  input  DATA_WIDTH  store data, right-justified.
- resp_valid_o  output  1  one-cycle completion pulse.
- resp_err_o  output  1  error flag, valid with resp_valid_o.
- resp_rdata_o  output  DATA_WIDTH  load result, valid with resp_valid_o.
- mem_we_o  output  1  memory write enable.
- mem_addr_o  output  DATA_WIDTH  word-aligned memory address.
- mem_wdata_o  output  DATA_WIDTH  memory write data.
- mem_rdata_i  input  DATA_WIDTH  memory read data.

Behaviour:
- Reset (async): state IDLE; all outputs 0. req_ready_o is 0 while reset is high and 1 in IDLE afterwards. Reset mid-operation aborts the access: mem_we_o falls immediately, no response is issued, and a pending RMW is never written.
- Handshake: req_ready_o = (state==IDLE). A request is accepted at the clock edge T0 where req_valid_i && req_ready_o. All request fields are latched at T0, and the bench may change them afterwards. Only one request is outstanding at a time.
- Error check at acceptance: misaligned half (addr[0]=1), misaligned word (addr[1:0]!=0), size 11, or store with addr < RAM_BASE. An error moves the FSM to RESP and makes no memory access (mem_we_o stays 0).
  - resp_err_o = 1 and resp_rdata_o = 0 on the response.
- mem_addr_o = {addr[31:2],2'b00}, registered, held from T0 until return to IDLE. Lanes are little-endian: byte k occupies bits 8k+7:8k.
- FSM states: IDLE, RD_WAIT, WR, RESP.
  - IDLE -> RD_WAIT: load, or sub-word store.
  - IDLE -> WR: word store.
  - IDLE -> RESP: error.
  - RD_WAIT: a counter runs READ_LAT cycles, then mem_rdata_i is sampled at edge T0+READ_LAT.
    - Load -> RESP.
    - Sub-word store -> WR, with the merged word latched (only the addressed byte or half is replaced).
  - WR: mem_we_o = 1 for exactly one cycle; mem_wdata_o = word, or the merged word. -> RESP.
  - RESP: resp_valid_o = 1 for exactly one cycle. -> IDLE.
- Load result: the addressed lane is shifted to bit 0, then zero-extended, or sign-extended when req_sign_i = 1. A word load returns the full word.
- Latency, with response cycle measured from T0:
  - load: READ_LAT+1;
  - word store: 2;
  - sub-word store: READ_LAT+2;
  - error: 1.
- Back-to-back: earliest next acceptance is the edge after the RESP cycle.
- mem_wdata_o holds its value outside WR. resp_rdata_o holds until the next response.

Optional Feature:
- Macro MEM_ACCESS_STATS_EN. When defined, adds three output ports, each 16 bits, saturating at 16'hFFFF, cleared by reset:
  - rd_count_o, incremented on each successful load response;
  - wr_count_o, incremented on each successful store response;
  - err_count_o, incremented on each error response.
- When undefined, these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Word load, addr 32'h1000_0004, memory word 32'hCAFE_BABE, READ_LAT=1 -> mem_addr_o=32'h1000_0004, resp_valid_o at T0+2, resp_rdata_o=32'hCAFE_BABE, resp_err_o=0, mem_we_o never 1.
- Signed byte load, addr 32'h1000_0003, word 32'h80FF_0012 -> resp_rdata_o=32'hFFFF_FF80. Unsigned -> 32'h0000_0080.
- Half store 16'hBEEF at 32'h1000_0002 over existing word 32'h1122_3344 -> single mem_we_o pulse with mem_wdata_o=32'hBEEF_3344, response at T0+3.
- Word store to 32'h0040_0000 (ROM), and word load from 32'h1000_0001 -> each gives resp_err_o=1 at T0+1 and mem_we_o stays 0.
- req_valid_i held high for two word stores -> second accepted only at the edge after the first RESP cycle; req_ready_o=0 in between.
- Reset asserted during the WR cycle of a sub-word store -> mem_we_o drops asynchronously, no resp_valid_o, req_ready_o=1 after release. With MEM_ACCESS_STATS_EN, all counters read 0.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake and word-addressed memory bus of mem_access_ctrl.
// slave = controller side, master = requester/memory side.
interface mem_access_ctrl_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  req_valid_i;
   logic                  req_ready_o;
   logic                  req_we_i;
   logic [1:0]            req_size_i;
   logic                  req_sign_i;
   logic [DATA_WIDTH-1:0] req_addr_i;
   logic [DATA_WIDTH-1:0] req_wdata_i;
   logic                  resp_valid_o;
   logic                  resp_err_o;
   logic [DATA_WIDTH-1:0] resp_rdata_o;
   logic                  mem_we_o;
   logic [DATA_WIDTH-1:0] mem_addr_o;
   logic [DATA_WIDTH-1:0] mem_wdata_o;
   logic [DATA_WIDTH-1:0] mem_rdata_i;

   modport slave (
      input  req_valid_i, req_we_i, req_size_i, req_sign_i, req_addr_i, req_wdata_i, mem_rdata_i,
      output req_ready_o, resp_valid_o, resp_err_o, resp_rdata_o, mem_we_o, mem_addr_o, mem_wdata_o
   );

   modport master (
      output req_valid_i, req_we_i, req_size_i, req_sign_i, req_addr_i, req_wdata_i, mem_rdata_i,
      input  req_ready_o, resp_valid_o, resp_err_o, resp_rdata_o, mem_we_o, mem_addr_o, mem_wdata_o
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Multicycle MIPS memory access controller: byte/half/word loads and stores with RMW.
// Optional macro MEM_ACCESS_STATS_EN adds saturating load/store/error counters.
module mem_access_ctrl #(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RAM_BASE   = 32'h1000_0000,
   parameter int unsigned           READ_LAT   = 1
) (
   input logic              clk,
   input logic              reset,
   mem_access_ctrl_if.slave bus
`ifdef MEM_ACCESS_STATS_EN
   ,
   output logic [15:0]      rd_count_o,
   output logic [15:0]      wr_count_o,
   output logic [15:0]      err_count_o
`endif
);

   typedef enum logic [1:0] {IDLE, RD_WAIT, WR, RESP} state_t;

   localparam int unsigned CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

   state_t                state, state_nxt;
   logic [CNT_W-1:0]      cnt;
   logic                  we_q, sign_q, err_q;
   logic [1:0]            size_q, lane_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  accept, req_err, rd_done;
   logic [DATA_WIDTH-1:0] shifted, load_val, lane_mask, merge_val;

   assign accept  = bus.req_valid_i && (state == IDLE);
   assign rd_done = (cnt == '0);

   always_comb begin
      req_err = 1'b0;
      case (bus.req_size_i)
         2'b00:   req_err = 1'b0;
         2'b01:   req_err = bus.req_addr_i[0];
         2'b10:   req_err = |bus.req_addr_i[1:0];
         default: req_err = 1'b1;
      endcase
      if (bus.req_we_i && (bus.req_addr_i < RAM_BASE))
         req_err = 1'b1;
   end

   // Halves are always lane-aligned, so a byte-granular shift serves both sizes.
   always_comb begin
      shifted = bus.mem_rdata_i >> {lane_q, 3'b000};
      case (size_q)
         2'b00:   load_val = {{(DATA_WIDTH-8){sign_q & shifted[7]}}, shifted[7:0]};
         2'b01:   load_val = {{(DATA_WIDTH-16){sign_q & shifted[15]}}, shifted[15:0]};
         default: load_val = bus.mem_rdata_i;
      endcase
   end

   always_comb begin
      lane_mask = (size_q == 2'b00) ? DATA_WIDTH'(8'hFF) : DATA_WIDTH'(16'hFFFF);
      lane_mask = lane_mask << {lane_q, 3'b000};
      merge_val = (bus.mem_rdata_i & ~lane_mask) | ((wdata_q << {lane_q, 3'b000}) & lane_mask);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (req_err)                                       state_nxt = RESP;
               else if (bus.req_we_i && bus.req_size_i == 2'b10)  state_nxt = WR;
               else                                               state_nxt = RD_WAIT;
            end
         end
         RD_WAIT: if (rd_done) state_nxt = we_q ? WR : RESP;
         WR:      state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready_o  = (state == IDLE) && !reset;
      bus.resp_valid_o = (state == RESP);
      bus.resp_err_o   = (state == RESP) && err_q;
      bus.mem_we_o     = (state == WR);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt              <= '0;
         we_q             <= 1'b0;
         sign_q           <= 1'b0;
         err_q            <= 1'b0;
         size_q           <= '0;
         lane_q           <= '0;
         wdata_q          <= '0;
         bus.mem_addr_o   <= '0;
         bus.mem_wdata_o  <= '0;
         bus.resp_rdata_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  we_q           <= bus.req_we_i;
                  sign_q         <= bus.req_sign_i;
                  err_q          <= req_err;
                  size_q         <= bus.req_size_i;
                  lane_q         <= bus.req_addr_i[1:0];
                  wdata_q        <= bus.req_wdata_i;
                  cnt            <= CNT_W'(READ_LAT - 1);
                  bus.mem_addr_o <= {bus.req_addr_i[DATA_WIDTH-1:2], 2'b00};
                  if (req_err)
                     bus.resp_rdata_o <= '0;
                  else if (bus.req_we_i && bus.req_size_i == 2'b10)
                     bus.mem_wdata_o <= bus.req_wdata_i;
               end
            end
            RD_WAIT: begin
               if (rd_done) begin
                  if (we_q) bus.mem_wdata_o  <= merge_val;
                  else      bus.resp_rdata_o <= load_val;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            WR:      bus.resp_rdata_o <= '0;
            default: ;
         endcase
      end
   end

`ifdef MEM_ACCESS_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_count_o  <= '0;
         wr_count_o  <= '0;
         err_count_o <= '0;
      end else if (state == RESP) begin
         if (err_q) begin
            if (err_count_o != '1) err_count_o <= err_count_o + 1'b1;
         end else if (we_q) begin
            if (wr_count_o != '1) wr_count_o <= wr_count_o + 1'b1;
         end else begin
            if (rd_count_o != '1) rd_count_o <= rd_count_o + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: behavioural memory/transaction model,
// per-cycle compare process and directed vectors with literal expectations.
module tb_mem_access_ctrl;
   localparam int unsigned DW       = 32;
   localparam logic [31:0] RAM_BASE = 32'h1000_0000;
   localparam int unsigned RL       = 1;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   mem_access_ctrl_if #(.DATA_WIDTH(DW)) bus ();

`ifdef MEM_ACCESS_STATS_EN
   logic [15:0] rd_count, wr_count, err_count;
`endif

   mem_access_ctrl #(
      .DATA_WIDTH(DW),
      .RAM_BASE  (RAM_BASE),
      .READ_LAT  (RL)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
`ifdef MEM_ACCESS_STATS_EN
      ,
      .rd_count_o (rd_count),
      .wr_count_o (wr_count),
      .err_count_o(err_count)
`endif
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] idx(input logic [31:0] a);
      return {a[31:28], a[5:2]};
   endfunction

   // Environment memory (answers the DUT) and preload port
   logic [31:0] env_mem [256] = '{default: '0};
   logic        pl_en   = 1'b0;
   logic [31:0] pl_addr = '0;
   logic [31:0] pl_val  = '0;

   always @(posedge clk) begin
      if (bus.mem_we_o)  env_mem[idx(bus.mem_addr_o)] <= bus.mem_wdata_o;
      else if (pl_en)    env_mem[idx(pl_addr)]       <= pl_val;
   end
   assign bus.mem_rdata_i = env_mem[idx(bus.mem_addr_o)];

   // Reference model: one transaction at a time, cycle numbers counted from acceptance
   logic [31:0] ref_mem [256] = '{default: '0};
   bit          busy = 1'b0, acc;
   int          cyc, n_lat, wr_cyc;
   logic [31:0] exp_addr, exp_wdata, exp_rdata;
   bit          exp_err, exp_we;
   logic [15:0] m_rd = '0, m_wr = '0, m_err = '0;

   task automatic model_accept();
      logic [31:0] a, old, w;
      int          ln, nb;
      logic [1:0]  sz;
      a        = bus.req_addr_i;
      sz       = bus.req_size_i;
      exp_we   = bus.req_we_i;
      busy     = 1'b1;
      cyc      = 1;
      wr_cyc   = 0;
      exp_addr = a & ~32'h3;
      exp_rdata = '0;
      exp_err  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) ||
                 (exp_we && a < RAM_BASE);
      if (exp_err) begin
         n_lat = 1;
      end else begin
         old = ref_mem[idx(a)];
         ln  = int'(a[1:0]);
         nb  = 1 << sz;
         if (!exp_we) begin
            n_lat = RL + 1;
            for (int k = 0; k < nb; k++) exp_rdata[8*k +: 8] = old[8*(ln+k) +: 8];
            if (nb < 4 && bus.req_sign_i && exp_rdata[8*nb-1])
               for (int k = nb; k < 4; k++) exp_rdata[8*k +: 8] = 8'hFF;
         end else begin
            n_lat  = (nb == 4) ? 2 : RL + 2;
            wr_cyc = n_lat - 1;
            w = old;
            for (int k = 0; k < nb; k++) w[8*(ln+k) +: 8] = bus.req_wdata_i[8*k +: 8];
            exp_wdata = w;
         end
      end
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         busy  = 1'b0;
         cyc   = 0;
         m_rd  = '0;
         m_wr  = '0;
         m_err = '0;
      end else begin
         acc = bus.req_valid_i && !busy;
         if (busy) begin
            if (cyc == wr_cyc) ref_mem[idx(exp_addr)] = exp_wdata;
            if (cyc == n_lat) begin
               busy = 1'b0;
               if (exp_err)     begin if (m_err != 16'hFFFF) m_err++; end
               else if (exp_we) begin if (m_wr  != 16'hFFFF) m_wr++;  end
               else             begin if (m_rd  != 16'hFFFF) m_rd++;  end
            end else begin
               cyc++;
            end
         end else if (pl_en) begin
            ref_mem[idx(pl_addr)] = pl_val;
         end
         if (acc) model_accept();
      end
   end

   // Per-cycle compare against the model
   always @(negedge clk) begin
      if (reset) begin
         check("rst_ready",      32'(bus.req_ready_o),  32'd0);
         check("rst_resp_valid", 32'(bus.resp_valid_o), 32'd0);
         check("rst_mem_we",     32'(bus.mem_we_o),     32'd0);
      end else begin
         check("ready",      32'(bus.req_ready_o),  32'(!busy));
         check("resp_valid", 32'(bus.resp_valid_o), 32'(busy && cyc == n_lat));
         check("mem_we",     32'(bus.mem_we_o),     32'(busy && cyc == wr_cyc));
         if (busy) begin
            check("mem_addr", bus.mem_addr_o, exp_addr);
            if (cyc == wr_cyc) check("mem_wdata", bus.mem_wdata_o, exp_wdata);
            if (cyc == n_lat) begin
               check("resp_err", 32'(bus.resp_err_o), 32'(exp_err));
               if (exp_err || !exp_we) check("resp_rdata", bus.resp_rdata_o, exp_rdata);
            end
         end
`ifdef MEM_ACCESS_STATS_EN
         check("rd_count",  32'(rd_count),  32'(m_rd));
         check("wr_count",  32'(wr_count),  32'(m_wr));
         check("err_count", 32'(err_count), 32'(m_err));
`endif
      end
   end

   // Directed driver
   task automatic preload(input logic [31:0] a, input logic [31:0] v);
      @(negedge clk);
      pl_addr = a;
      pl_val  = v;
      pl_en   = 1'b1;
      @(posedge clk);
      #1 pl_en = 1'b0;
   endtask

   task automatic drive(input logic we, input logic [1:0] size, input logic sign,
                        input logic [31:0] addr, input logic [31:0] wdata);
      bus.req_we_i    = we;
      bus.req_size_i  = size;
      bus.req_sign_i  = sign;
      bus.req_addr_i  = addr;
      bus.req_wdata_i = wdata;
      bus.req_valid_i = 1'b1;
   endtask

   task automatic wait_accept(output bit ok, output int waits);
      ok = 1'b0;
      waits = 0;
      while (!ok && waits < 20) begin
         if (bus.req_ready_o) begin
            @(posedge clk);
            #1 ok = 1'b1;
         end else begin
            @(negedge clk);
            waits++;
         end
      end
      if (!ok) check("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_resp(input string name, input int exp_lat, input logic exp_e,
                            input bit chk_rd, input logic [31:0] exp_rd);
      int k;
      bit got = 1'b0;
      for (k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (bus.resp_valid_o) begin
            got = 1'b1;
            break;
         end
      end
      check({name, "_lat"}, 32'(k), 32'(exp_lat));
      if (got) begin
         check({name, "_err"}, 32'(bus.resp_err_o), 32'(exp_e));
         check({name, "_model_lat"}, 32'(n_lat), 32'(exp_lat));
         if (chk_rd) begin
            check({name, "_rdata"}, bus.resp_rdata_o, exp_rd);
            check({name, "_model_rd"}, exp_rdata, exp_rd);
         end
      end
   endtask

   task automatic do_req(input string name, input logic we, input logic [1:0] size,
                         input logic sign, input logic [31:0] addr, input logic [31:0] wdata,
                         input int exp_lat, input logic exp_e, input bit chk_rd,
                         input logic [31:0] exp_rd);
      bit ok;
      int w;
      @(negedge clk);
      drive(we, size, sign, addr, wdata);
      wait_accept(ok, w);
      bus.req_valid_i = 1'b0;
      bus.req_addr_i  = 32'hDEAD_BEEF;
      bus.req_wdata_i = 32'h0BAD_F00D;
      if (ok) wait_resp(name, exp_lat, exp_e, chk_rd, exp_rd);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int w, k;
      bus.req_valid_i = 1'b0;
      bus.req_we_i    = 1'b0;
      bus.req_size_i  = 2'b00;
      bus.req_sign_i  = 1'b0;
      bus.req_addr_i  = '0;
      bus.req_wdata_i = '0;

      repeat (3) @(negedge clk);
      check("rst_mem_addr",   bus.mem_addr_o,   32'h0);
      check("rst_resp_rdata", bus.resp_rdata_o, 32'h0);
      #2 reset = 1'b0;
      @(negedge clk);
      check("ready_after_rst", 32'(bus.req_ready_o), 32'd1);

      preload(32'h1000_0004, 32'hCAFE_BABE);
      preload(32'h1000_0000, 32'h80FF_0012);

      do_req("ld_word",  1'b0, 2'b10, 1'b0, 32'h1000_0004, '0, 2, 1'b0, 1'b1, 32'hCAFE_BABE);
      do_req("ld_sbyte", 1'b0, 2'b00, 1'b1, 32'h1000_0003, '0, 2, 1'b0, 1'b1, 32'hFFFF_FF80);
      do_req("ld_ubyte", 1'b0, 2'b00, 1'b0, 32'h1000_0003, '0, 2, 1'b0, 1'b1, 32'h0000_0080);

      preload(32'h1000_0000, 32'h1122_3344);
      do_req("st_half",  1'b1, 2'b01, 1'b0, 32'h1000_0002, 32'h0000_BEEF, 3, 1'b0, 1'b0, '0);
      do_req("ld_merged",1'b0, 2'b10, 1'b0, 32'h1000_0000, '0, 2, 1'b0, 1'b1, 32'hBEEF_3344);
      do_req("ld_shalf", 1'b0, 2'b01, 1'b1, 32'h1000_0002, '0, 2, 1'b0, 1'b1, 32'hFFFF_BEEF);
      do_req("ld_uhalf", 1'b0, 2'b01, 1'b0, 32'h1000_0000, '0, 2, 1'b0, 1'b1, 32'h0000_3344);

      do_req("st_byte",  1'b1, 2'b00, 1'b0, 32'h1000_0005, 32'h1234_56A5, 3, 1'b0, 1'b0, '0);
      do_req("ld_byte_m",1'b0, 2'b10, 1'b0, 32'h1000_0004, '0, 2, 1'b0, 1'b1, 32'hCAFE_A5BE);

      do_req("st_rom",   1'b1, 2'b10, 1'b0, 32'h0040_0000, 32'h5555_5555, 1, 1'b1, 1'b1, 32'h0);
      do_req("ld_mis_w", 1'b0, 2'b10, 1'b0, 32'h1000_0001, '0, 1, 1'b1, 1'b1, 32'h0);
      do_req("ld_size3", 1'b0, 2'b11, 1'b0, 32'h1000_0004, '0, 1, 1'b1, 1'b1, 32'h0);
      do_req("st_mis_h", 1'b1, 2'b01, 1'b0, 32'h1000_0001, 32'h0000_1111, 1, 1'b1, 1'b1, 32'h0);

      // Back-to-back word stores with valid held high
      @(negedge clk);
      drive(1'b1, 2'b10, 1'b0, 32'h1000_0008, 32'h1234_5678);
      wait_accept(ok, w);
      drive(1'b1, 2'b10, 1'b0, 32'h1000_000C, 32'h9ABC_DEF0);
      wait_accept(ok, w);
      check("b2b_accept_wait", 32'(w), 32'd3);
      bus.req_valid_i = 1'b0;
      if (ok) wait_resp("b2b_second", 2, 1'b0, 1'b0, '0);
      do_req("ld_b2b_1", 1'b0, 2'b10, 1'b0, 32'h1000_0008, '0, 2, 1'b0, 1'b1, 32'h1234_5678);
      do_req("ld_b2b_2", 1'b0, 2'b10, 1'b0, 32'h1000_000C, '0, 2, 1'b0, 1'b1, 32'h9ABC_DEF0);

      // Reset during the write cycle of a sub-word store
      preload(32'h1000_0010, 32'h5566_7788);
      @(negedge clk);
      drive(1'b1, 2'b00, 1'b0, 32'h1000_0011, 32'h0000_00A5);
      wait_accept(ok, w);
      bus.req_valid_i = 1'b0;
      for (k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bus.mem_we_o) break;
      end
      check("rst_wr_seen", 32'(bus.mem_we_o), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("rst_we_async",    32'(bus.mem_we_o),     32'd0);
      check("rst_no_resp",     32'(bus.resp_valid_o), 32'd0);
      check("rst_ready_low",   32'(bus.req_ready_o),  32'd0);
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      check("rst_ready_after", 32'(bus.req_ready_o),  32'd1);
      check("rst_no_resp_after", 32'(bus.resp_valid_o), 32'd0);
`ifdef MEM_ACCESS_STATS_EN
      check("rst_rd_count",  32'(rd_count),  32'd0);
      check("rst_wr_count",  32'(wr_count),  32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);
`endif
      do_req("ld_unwritten", 1'b0, 2'b10, 1'b0, 32'h1000_0010, '0, 2, 1'b0, 1'b1, 32'h5566_7788);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
